// File: rtl/membus_arbiter_pkg.sv
// Shared membus definitions: default bus widths and the arbiter state encoding.
// Imported by the arbiter top level and anything else that talks to the peripheral bus.
package membus_arbiter_pkg;

  localparam int MEMBUS_ADDR_W = 7;
  localparam int MEMBUS_DATA_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_ACK   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/membus_arbiter_if.sv
// Requester-side and membus-side signals of the arbiter, bundled into one interface.
// The arbiter uses the slave modport; the requesters/peripherals use master.
interface membus_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ-1:0]        we_i;
  logic [NUM_REQ*ADDR_W-1:0] addr_i;
  logic [NUM_REQ*DATA_W-1:0] wdata_i;
  logic [NUM_REQ-1:0]        ack_o;
  logic [DATA_W-1:0]         rdata_o;
  logic                      busy_o;
  logic                      membus_read_req_o;
  logic                      membus_write_req_o;
  logic [ADDR_W-1:0]         membus_addr_o;
  logic [DATA_W-1:0]         membus_data_o;
  logic [DATA_W-1:0]         membus_data_i;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, membus_data_i,
    output ack_o, rdata_o, busy_o, membus_read_req_o, membus_write_req_o,
           membus_addr_o, membus_data_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, membus_data_i,
    input  ack_o, rdata_o, busy_o, membus_read_req_o, membus_write_req_o,
           membus_addr_o, membus_data_o
  );
endinterface

// File: rtl/membus_arbiter_rr_grant.sv
// Round-robin grant selector: the first active requester after i_ptr, wrapping.
// Purely combinational so other arbiters can reuse it.
module membus_arbiter_rr_grant #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_grant,
  output logic               o_valid
);

  // w_cand[k] is the requester index k+1 places after the pointer.
  logic [IDX_W-1:0] w_cand [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    assign w_cand[gi] = IDX_W'((int'(i_ptr) + gi + 1) % NUM_REQ);
  end

  // Scan from farthest to nearest so the nearest active candidate wins.
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[w_cand[k]]) begin
        o_grant = w_cand[k];
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/membus_arbiter.sv
// Round-robin arbiter for the shared peripheral membus: FSM, field latches, wait counter, registered outputs.
// Macro MEMBUS_ARB_WRITE_EN enables write strobes; without it writes are acked with no bus strobe.
module membus_arbiter
  import membus_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_W       = MEMBUS_ADDR_W,
  parameter int DATA_W       = MEMBUS_DATA_W,
  parameter int READ_LATENCY = 1
) (
  input logic             clk_i,
  input logic             rst_i,
  membus_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = 2;

  arb_state_t         r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_grant;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_rdata;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_REQ-1:0] r_ack;
  logic               r_busy;
  logic               r_rd_req;
`ifdef MEMBUS_ARB_WRITE_EN
  logic               r_wr_req;
`endif

  logic [IDX_W-1:0]   w_grant;
  logic               w_valid;
  logic [ADDR_W-1:0]  w_addr  [NUM_REQ];
  logic [DATA_W-1:0]  w_wdata [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_addr[gi]  = bus.addr_i[gi*ADDR_W +: ADDR_W];
    assign w_wdata[gi] = bus.wdata_i[gi*DATA_W +: DATA_W];
  end

  membus_arbiter_rr_grant #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_grant (
    .i_req   (bus.req_i),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_valid (w_valid)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ARB_IDLE;
      r_ptr    <= IDX_W'(NUM_REQ - 1);
      r_grant  <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_cnt    <= '0;
      r_ack    <= '0;
      r_busy   <= 1'b0;
      r_rd_req <= 1'b0;
`ifdef MEMBUS_ARB_WRITE_EN
      r_wr_req <= 1'b0;
`endif
    end else begin
      // Strobes and ack are single-cycle pulses by default.
      r_rd_req <= 1'b0;
`ifdef MEMBUS_ARB_WRITE_EN
      r_wr_req <= 1'b0;
`endif
      r_ack    <= '0;
      case (r_state)
        ARB_IDLE: begin
          if (w_valid) begin
            r_grant  <= w_grant;
            r_ptr    <= w_grant;
            r_we     <= bus.we_i[w_grant];
            r_addr   <= w_addr[w_grant];
            r_wdata  <= w_wdata[w_grant];
            r_rd_req <= ~bus.we_i[w_grant];
`ifdef MEMBUS_ARB_WRITE_EN
            r_wr_req <= bus.we_i[w_grant];
`endif
            r_busy   <= 1'b1;
            r_state  <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (r_we) begin
            r_ack   <= NUM_REQ'(1) << r_grant;
            r_state <= ARB_ACK;
          end else begin
            r_cnt   <= CNT_W'(READ_LATENCY);
            r_state <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          // Count of 1 marks the edge at which the peripheral data is valid.
          if (r_cnt == CNT_W'(1)) begin
            r_rdata <= bus.membus_data_i;
            r_ack   <= NUM_REQ'(1) << r_grant;
            r_state <= ARB_ACK;
          end
        end
        ARB_ACK: begin
          r_busy  <= 1'b0;
          r_state <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign bus.ack_o              = r_ack;
  assign bus.rdata_o            = r_rdata;
  assign bus.busy_o             = r_busy;
  assign bus.membus_read_req_o  = r_rd_req;
  assign bus.membus_addr_o      = r_addr;
  assign bus.membus_data_o      = r_wdata;
`ifdef MEMBUS_ARB_WRITE_EN
  assign bus.membus_write_req_o = r_wr_req;
`else
  assign bus.membus_write_req_o = 1'b0;
`endif

endmodule

// File: tb/tb_membus_arbiter.sv
// Randomized bench for membus_arbiter against a transaction-level timing model.
// Two instances: READ_LATENCY=1 and READ_LATENCY=3, exercised one after the other.
module tb_membus_arbiter;

  localparam int NR = 2;
  localparam int AW = 7;
  localparam int DW = 8;
`ifdef MEMBUS_ARB_WRITE_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_d   [2];
  logic [NR-1:0]     req_d   [2];
  logic [NR-1:0]     we_d    [2];
  logic [NR*AW-1:0]  addr_d  [2];
  logic [NR*DW-1:0]  wdata_d [2];
  logic [DW-1:0]     mdi_d   [2];
  logic [NR-1:0]     ack_s   [2];
  logic [DW-1:0]     rdata_s [2];
  logic              busy_s  [2];
  logic              rs_s    [2];
  logic              ws_s    [2];
  logic [AW-1:0]     ma_s    [2];
  logic [DW-1:0]     md_s    [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
    localparam int RL = (gi == 0) ? 1 : 3;
    membus_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();
    assign bus.req_i         = req_d[gi];
    assign bus.we_i          = we_d[gi];
    assign bus.addr_i        = addr_d[gi];
    assign bus.wdata_i       = wdata_d[gi];
    assign bus.membus_data_i = mdi_d[gi];
    assign ack_s[gi]   = bus.ack_o;
    assign rdata_s[gi] = bus.rdata_o;
    assign busy_s[gi]  = bus.busy_o;
    assign rs_s[gi]    = bus.membus_read_req_o;
    assign ws_s[gi]    = bus.membus_write_req_o;
    assign ma_s[gi]    = bus.membus_addr_o;
    assign md_s[gi]    = bus.membus_data_o;
    membus_arbiter #(
      .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)
    ) dut (
      .clk_i (clk),
      .rst_i (rst_d[gi]),
      .bus   (bus)
    );
  end

  int checks = 0;
  int errors = 0;

  // Model state: one access in flight, described by its grant cycle t0.
  int            cfg, cyc, rl;
  bit            act;
  int            t0, ack_cyc, g, ptr;
  bit            mwe;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mwd, cap, mrd;
  logic [DW-1:0] mem [128];
  // Requester agents.
  bit            hold [NR], cool [NR], gr [NR], want [NR];
  bit            hwe [NR];
  logic [AW-1:0] haddr [NR];
  logic [DW-1:0] hwd [NR];
  bit            rnd_en, persist, have_last;
  logic [NR-1:0] last_ack;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cfg=%0d cyc=%0d got=%0h want=%0h", tag, cfg, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    act = 1'b0;
    ptr = NR - 1;
    mrd = '0;
    have_last = 1'b0;
    for (int r = 0; r < NR; r++) begin
      hold[r] = 1'b0; cool[r] = 1'b0; gr[r] = 1'b0; want[r] = 1'b0;
    end
  endtask

  task automatic check_outputs();
    bit            inwin;
    logic [NR-1:0] e_ack;
    logic [DW-1:0] e_rd;
    inwin = act && cyc >= t0 + 1 && cyc <= ack_cyc;
    e_ack = (act && cyc == ack_cyc) ? (NR'(1) << g) : '0;
    e_rd  = (act && cyc == ack_cyc && !mwe) ? cap : mrd;
    check("busy",   32'(busy_s[cfg]), 32'(inwin));
    check("rd_req", 32'(rs_s[cfg]),   32'(act && cyc == t0 + 1 && !mwe));
    check("wr_req", 32'(ws_s[cfg]),   32'(act && cyc == t0 + 1 && mwe && WR_EN));
    check("ack",    32'(ack_s[cfg]),  32'(e_ack));
    check("rdata",  32'(rdata_s[cfg]), 32'(e_rd));
    if (inwin && (!mwe || WR_EN)) begin
      check("bus_addr", 32'(ma_s[cfg]), 32'(maddr));
      check("bus_data", 32'(md_s[cfg]), 32'(mwd));
    end
    if (act && cyc == ack_cyc) begin
      $display("txn cfg=%0d rl=%0d cyc=%0d req=%0d %s addr=%02h data=%02h ack=%b",
               cfg, rl, cyc, g, mwe ? "WR" : "RD", maddr, mwe ? mwd : cap, ack_s[cfg]);
      if (persist && have_last)
        check("rr_alternate", 32'(ack_s[cfg] != last_ack), 32'd1);
      last_ack  = ack_s[cfg];
      have_last = 1'b1;
    end
  endtask

  task automatic drive_inputs();
    logic [NR-1:0]    rq, w;
    logic [NR*AW-1:0] a;
    logic [NR*DW-1:0] d;
    for (int r = 0; r < NR; r++) begin
      if (!hold[r] && !cool[r]) begin
        if (persist || (rnd_en && $urandom_range(0, 2) == 0)) begin
          want[r]  = 1'b1;
          hwe[r]   = persist ? 1'b0 : 1'($urandom_range(0, 1));
          haddr[r] = AW'($urandom);
          hwd[r]   = DW'($urandom);
        end
        if (want[r]) begin
          hold[r] = 1'b1;
          want[r] = 1'b0;
        end
      end else if (hold[r] && !gr[r] && rnd_en && $urandom_range(0, 11) == 0) begin
        hold[r] = 1'b0;
      end
      rq[r] = hold[r] && !cool[r];
      // Once granted, scrambling the fields must not disturb the access.
      if (gr[r] && rnd_en) begin
        w[r] = 1'($urandom_range(0, 1));
        a[r*AW +: AW] = AW'($urandom);
        d[r*DW +: DW] = DW'($urandom);
      end else begin
        w[r] = hwe[r];
        a[r*AW +: AW] = haddr[r];
        d[r*DW +: DW] = hwd[r];
      end
      cool[r] = 1'b0;
    end
    if (act && !mwe && cyc == t0 + 1 + rl) begin
      cap = mem[maddr];
      mdi_d[cfg] = cap;
    end else begin
      mdi_d[cfg] = DW'($urandom);
    end
    req_d[cfg] = rq; we_d[cfg] = w; addr_d[cfg] = a; wdata_d[cfg] = d;
  endtask

  task automatic model_update();
    logic [NR-1:0] rq;
    bit            found;
    rq = req_d[cfg];
    if (act && cyc == t0 + 1 && mwe && WR_EN) mem[maddr] = mwd;
    if (act && cyc == ack_cyc) begin
      hold[g] = 1'b0; gr[g] = 1'b0; cool[g] = 1'b1;
      if (!mwe) mrd = cap;
    end
    if (!act || cyc > ack_cyc) begin
      found = 1'b0;
      for (int i = 1; i <= NR; i++) begin
        int c;
        c = (ptr + i) % NR;
        if (!found && rq[c]) begin
          found   = 1'b1;
          act     = 1'b1;
          t0      = cyc;
          g       = c;
          ptr     = c;
          mwe     = we_d[cfg][c];
          maddr   = addr_d[cfg][c*AW +: AW];
          mwd     = wdata_d[cfg][c*DW +: DW];
          ack_cyc = cyc + 2 + (mwe ? 0 : rl);
          gr[c]   = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    drive_inputs();
    model_update();
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_d[cfg] = 1'b1;
    req_d[cfg] = '0;
    #1;
    check("rst_busy",   32'(busy_s[cfg]),  32'd0);
    check("rst_rd_req", 32'(rs_s[cfg]),    32'd0);
    check("rst_wr_req", 32'(ws_s[cfg]),    32'd0);
    check("rst_ack",    32'(ack_s[cfg]),   32'd0);
    check("rst_rdata",  32'(rdata_s[cfg]), 32'd0);
    check("rst_addr",   32'(ma_s[cfg]),    32'd0);
    check("rst_data",   32'(md_s[cfg]),    32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_d[cfg] = 1'b0;
    cyc += 3;
  endtask

  task automatic set_want(input int r, input bit we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    want[r] = 1'b1; hwe[r] = we; haddr[r] = ad; hwd[r] = wd;
  endtask

  initial begin
    for (int c = 0; c < 2; c++) begin
      rst_d[c] = 1'b1; req_d[c] = '0; we_d[c] = '0;
      addr_d[c] = '0; wdata_d[c] = '0; mdi_d[c] = '0;
    end
    for (int c = 0; c < 2; c++) begin
      bit seen;
      cfg = c; rl = (c == 0) ? 1 : 3; cyc = 0;
      persist = 1'b0; rnd_en = 1'b0;
      for (int i = 0; i < 128; i++) mem[i] = DW'($urandom);
      do_reset();

      // Single read of the CO2 register.
      mem[7'h10] = 8'hA5;
      set_want(0, 1'b0, 7'h10, 8'h00);
      repeat (8) step();
      check("t1_rdata", 32'(rdata_s[cfg]), 32'h0000_00A5);

      // Single write; read data must not change.
      set_want(1, 1'b1, 7'h20, 8'h3C);
      repeat (8) step();
      check("t2_rdata_hold", 32'(rdata_s[cfg]), 32'h0000_00A5);

      // Contention: both requesters keep asking.
      have_last = 1'b0;
      persist = 1'b1;
      repeat (40) step();
      persist = 1'b0;
      repeat (20) step();

      // Reset one cycle after the read strobe.
      set_want(0, 1'b0, 7'h11, 8'h00);
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
        step();
        seen = act && cyc == t0 + 2;
      end
      check("rst_setup_reached", 32'(seen), 32'd1);
      do_reset();
      set_want(0, 1'b0, 7'h05, 8'h00);
      set_want(1, 1'b0, 7'h06, 8'h00);
      seen = 1'b0;
      for (int n = 0; n < 12 && !seen; n++) begin
        step();
        if (ack_s[cfg] != '0) begin
          seen = 1'b1;
          check("post_rst_grant", 32'(ack_s[cfg]), 32'd1);
        end
      end
      check("post_rst_ack_seen", 32'(seen), 32'd1);
      repeat (12) step();

      // Random traffic with withdrawals and post-grant field scrambling.
      rnd_en = 1'b1;
      repeat (600) step();
      rnd_en = 1'b0;
      repeat (20) step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
